// File: rtl/maze_food_pkg.sv
//------------------------------------------------------------------------------
// maze_food_pkg
// Shared food-map encodings, grid geometry and default score weights.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package maze_food_pkg;

  localparam int GRID_W     = 10;
  localparam int GRID_H     = 15;
  localparam int NUM_CELLS  = GRID_W * GRID_H;
  localparam int CELL_IDX_W = 8;

  localparam logic [1:0] FOOD_NONE   = 2'b00;
  localparam logic [1:0] FOOD_NORMAL = 2'b01;
  localparam logic [1:0] FOOD_RARE   = 2'b10;
  localparam logic [1:0] FOOD_CRUX   = 2'b11;

  localparam int SCORE_NORMAL_DFLT = 1;
  localparam int SCORE_RARE_DFLT   = 5;
  localparam int SCORE_CRUX_DFLT   = 10;
  localparam int CRUX_TARGET_DFLT  = 3;

  typedef enum logic [1:0] {
    ST_WAIT_GEN = 2'd0,
    ST_READY    = 2'd1,
    ST_LOOKUP   = 2'd2,
    ST_DONE     = 2'd3
  } collector_state_e;

endpackage

`default_nettype wire

// File: rtl/maze_cell_index.sv
//------------------------------------------------------------------------------
// maze_cell_index
// Maps a grid coordinate to its linear cell index and flags out-of-grid moves.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module maze_cell_index
  import maze_food_pkg::*;
(
  input  logic [3:0]            x_i,
  input  logic [3:0]            y_i,
  output logic [CELL_IDX_W-1:0] idx_o,
  output logic                  in_range_o
);

  // y*10 as shift-add so no multiplier is inferred
  assign idx_o      = ({4'd0, y_i} << 3) + ({4'd0, y_i} << 1) + {4'd0, x_i};
  assign in_range_o = (x_i < 4'(GRID_W)) && (y_i < 4'(GRID_H));

endmodule

`default_nettype wire

// File: rtl/food_collector.sv
//------------------------------------------------------------------------------
// food_collector
// Resolves player moves against the food map, keeps score and crux progress.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module food_collector
  import maze_food_pkg::*;
#(
  parameter int SCORE_NORMAL = SCORE_NORMAL_DFLT,
  parameter int SCORE_RARE   = SCORE_RARE_DFLT,
  parameter int SCORE_CRUX   = SCORE_CRUX_DFLT,
  parameter int CRUX_TARGET  = CRUX_TARGET_DFLT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*NUM_CELLS-1:0] food,
  input  logic                   gen_busy,
  input  logic [3:0]             player_x,
  input  logic [3:0]             player_y,
  input  logic                   move_valid,
  output logic                   move_ready,
  output logic                   eat_valid,
  output logic [1:0]             eat_kind,
  output logic [15:0]            score,
  output logic [1:0]             crux_count,
  output logic                   all_crux,
  output logic [2*NUM_CELLS-1:0] visible_food
);

  collector_state_e      state_q, state_d;
  logic [CELL_IDX_W-1:0] idx_q, idx_d;
  logic                  vld_q, vld_d;
  logic [NUM_CELLS-1:0]  eaten_q, eaten_d;
  logic                  eat_valid_q, eat_valid_d;
  logic [1:0]            eat_kind_q, eat_kind_d;
  logic [15:0]           score_q, score_d;
  logic [1:0]            crux_q, crux_d;
  logic                  all_crux_q, all_crux_d;

  logic [CELL_IDX_W-1:0] w_idx;
  logic                  w_in_range;
  logic [1:0]            w_cell;
  logic [1:0]            w_eff;
  logic [16:0]           w_points;
  logic [16:0]           w_sum;
  logic [1:0]            w_crux_next;

  maze_cell_index u_cell_index (
    .x_i        (player_x),
    .y_i        (player_y),
    .idx_o      (w_idx),
    .in_range_o (w_in_range)
  );

  // An out-of-grid index is never dereferenced: vld_q gates the result
  assign w_cell = food[{idx_q, 1'b0} +: 2];
  assign w_eff  = (vld_q && !eaten_q[idx_q]) ? w_cell : FOOD_NONE;

  always_comb begin
    w_points = 17'd0;
    case (w_eff)
      FOOD_NORMAL: w_points = 17'(SCORE_NORMAL);
      FOOD_RARE:   w_points = 17'(SCORE_RARE);
      FOOD_CRUX:   w_points = 17'(SCORE_CRUX);
      default:     w_points = 17'd0;
    endcase
  end

  assign w_sum       = {1'b0, score_q} + w_points;
  assign w_crux_next = ((w_eff == FOOD_CRUX) && (crux_q < 2'(CRUX_TARGET)))
                       ? crux_q + 2'd1 : crux_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    vld_d       = vld_q;
    eaten_d     = eaten_q;
    eat_valid_d = 1'b0;
    eat_kind_d  = eat_kind_q;
    score_d     = score_q;
    crux_d      = crux_q;
    all_crux_d  = all_crux_q;
    move_ready  = 1'b0;
    case (state_q)
      ST_WAIT_GEN: begin
        if (!gen_busy) state_d = ST_READY;
      end
      ST_READY: begin
        move_ready = 1'b1;
        if (gen_busy) begin
          eaten_d = '0;
          state_d = ST_WAIT_GEN;
        end else if (move_valid) begin
          idx_d   = w_idx;
          vld_d   = w_in_range;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        // Regeneration wins over the pending lookup
        if (gen_busy) begin
          eaten_d = '0;
          state_d = ST_WAIT_GEN;
        end else begin
          eat_valid_d = 1'b1;
          eat_kind_d  = w_eff;
          if (w_eff != FOOD_NONE) begin
            eaten_d[idx_q] = 1'b1;
            score_d        = w_sum[16] ? 16'hFFFF : w_sum[15:0];
          end
          crux_d = w_crux_next;
          if (w_crux_next == 2'(CRUX_TARGET)) begin
            all_crux_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            state_d = ST_READY;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_WAIT_GEN;
      idx_q       <= '0;
      vld_q       <= 1'b0;
      eaten_q     <= '0;
      eat_valid_q <= 1'b0;
      eat_kind_q  <= FOOD_NONE;
      score_q     <= 16'd0;
      crux_q      <= 2'd0;
      all_crux_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      vld_q       <= vld_d;
      eaten_q     <= eaten_d;
      eat_valid_q <= eat_valid_d;
      eat_kind_q  <= eat_kind_d;
      score_q     <= score_d;
      crux_q      <= crux_d;
      all_crux_q  <= all_crux_d;
    end
  end

  generate
    for (genvar i = 0; i < NUM_CELLS; i++) begin : g_vis
      assign visible_food[2*i +: 2] = food[2*i +: 2] & {2{~eaten_q[i]}};
    end
  endgenerate

  assign eat_valid  = eat_valid_q;
  assign eat_kind   = eat_kind_q;
  assign score      = score_q;
  assign crux_count = crux_q;
  assign all_crux   = all_crux_q;

endmodule

`default_nettype wire

// File: tb/tb_food_collector.sv
//------------------------------------------------------------------------------
// tb_food_collector
// Directed moves against a transaction-level model of the food collector.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_food_collector;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [299:0] food = '0;
  logic         gen_busy = 1'b1;
  logic [3:0]   player_x = 4'd0;
  logic [3:0]   player_y = 4'd0;
  logic         move_valid = 1'b0;
  logic         move_ready;
  logic         eat_valid;
  logic [1:0]   eat_kind;
  logic [15:0]  score;
  logic [1:0]   crux_count;
  logic         all_crux;
  logic [299:0] visible_food;

  food_collector dut (
    .clk          (clk),
    .rst          (rst),
    .food         (food),
    .gen_busy     (gen_busy),
    .player_x     (player_x),
    .player_y     (player_y),
    .move_valid   (move_valid),
    .move_ready   (move_ready),
    .eat_valid    (eat_valid),
    .eat_kind     (eat_kind),
    .score        (score),
    .crux_count   (crux_count),
    .all_crux     (all_crux),
    .visible_food (visible_food)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int t;
  } move_t;

  bit    m_eaten [150];
  int    m_score;
  int    m_crux;
  bit    m_all;
  move_t pend[$];
  int    ncyc;
  int    total;
  int    bad;
  bit    chk_on;

  move_t m_pop;
  int    c_exp;
  int    idx_e;

  task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [299:0] exp_visible();
    logic [299:0] v;
    for (int i = 0; i < 150; i++)
      v[2*i +: 2] = m_eaten[i] ? 2'b00 : food[2*i +: 2];
    return v;
  endfunction

  function automatic int points(input int code);
    case (code)
      1:       return 1;
      2:       return 5;
      3:       return 10;
      default: return 0;
    endcase
  endfunction

  task automatic clear_mask();
    for (int i = 0; i < 150; i++) m_eaten[i] = 1'b0;
  endtask

  // Compare process: resolves each handshake against the model and checks the
  // architectural outputs every cycle.
  always @(negedge clk) begin
    ncyc++;
    if (chk_on) begin
      if (eat_valid) begin
        if (pend.size() == 0) begin
          chk("eat_spurious", eat_valid, 1'b0);
        end else begin
          m_pop = pend.pop_front();
          chk("eat_latency", ncyc, m_pop.t + 2);
          if (m_pop.x < 10 && m_pop.y < 15) begin
            idx_e = m_pop.y * 10 + m_pop.x;
            c_exp = m_eaten[idx_e] ? 0 : int'(food[2*idx_e +: 2]);
          end else begin
            idx_e = 0;
            c_exp = 0;
          end
          chk("eat_kind", eat_kind, c_exp);
          if (c_exp != 0) begin
            m_eaten[idx_e] = 1'b1;
            m_score = m_score + points(c_exp);
            if (m_score > 65535) m_score = 65535;
          end
          if (c_exp == 3 && m_crux < 3) m_crux++;
          if (m_crux == 3) m_all = 1'b1;
        end
      end else if (pend.size() > 0 && ncyc > pend[0].t + 2) begin
        chk("eat_missing", eat_valid, 1'b1);
        void'(pend.pop_front());
      end
      chk("score", score, m_score);
      chk("crux_count", crux_count, m_crux);
      chk("all_crux", all_crux, m_all);
      chk("visible_food", visible_food, exp_visible());
    end
  end

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      settle();
      if (move_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("ready_timeout", ok, 1'b1);
  endtask

  task automatic handshake(input int x, input int y, output bit ok);
    wait_ready(ok);
    if (ok) begin
      player_x   = 4'(x);
      player_y   = 4'(y);
      move_valid = 1'b1;
      @(posedge clk);
      pend.push_back('{x, y, ncyc});
      #2 move_valid = 1'b0;
    end
  endtask

  task automatic do_move(input int x, input int y);
    bit ok;
    handshake(x, y, ok);
  endtask

  task automatic model_reset();
    clear_mask();
    m_score = 0;
    m_crux  = 0;
    m_all   = 1'b0;
    pend.delete();
  endtask

  task automatic do_reset();
    settle();
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    #2 rst = 1'b0;
  endtask

  task automatic regen();
    bit ok;
    wait_ready(ok);
    gen_busy = 1'b1;
    @(posedge clk);
    clear_mask();
    pend.delete();
    #2 gen_busy = 1'b0;
  endtask

  task automatic abort_lookup(input int x, input int y, input bit use_rst);
    bit ok;
    handshake(x, y, ok);
    if (use_rst) rst = 1'b1;
    else         gen_busy = 1'b1;
    @(posedge clk);
    if (use_rst) model_reset();
    else begin
      clear_mask();
      pend.delete();
    end
    #2;
    rst      = 1'b0;
    gen_busy = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    food[47:46]   = 2'b01;
    food[299:298] = 2'b10;
    food[15:14]   = 2'b11;
    food[161:160] = 2'b11;
    food[291:290] = 2'b11;

    @(posedge clk);
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Generator busy: no moves accepted until the edge after it drops
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("ready_while_busy", move_ready, 1'b0);
    end
    gen_busy = 1'b0;
    chk("ready_before_edge", move_ready, 1'b0);
    settle();
    chk("ready_after_busy", move_ready, 1'b1);
    chk("score_reset", score, 16'd0);

    do_move(3, 2);
    settle();
    chk("first_eat_valid", eat_valid, 1'b1);
    chk("first_eat_kind", eat_kind, 2'b01);
    chk("first_score", score, 16'd1);
    chk("cell23_masked", visible_food[47:46], 2'b00);

    do_move(3, 2);
    settle();
    chk("reeat_kind", eat_kind, 2'b00);
    chk("reeat_score", score, 16'd1);

    do_move(9, 14);
    settle();
    chk("rare_score", score, 16'd6);
    chk("cell149_masked", visible_food[299:298], 2'b00);

    do_move(10, 0);
    settle();
    chk("offgrid_kind", eat_kind, 2'b00);
    chk("offgrid_score", score, 16'd6);

    regen();
    settle();
    chk("regen_unmasked", visible_food[47:46], 2'b01);

    abort_lookup(3, 2, 1'b0);
    abort_lookup(9, 14, 1'b1);
    chk("rst_lookup_score", score, 16'd0);

    do_move(7, 0);
    settle();
    chk("crux1", crux_count, 2'd1);
    do_move(0, 8);
    settle();
    chk("crux2", crux_count, 2'd2);
    do_move(5, 14);
    settle();
    chk("crux3", crux_count, 2'd3);
    chk("all_crux_set", all_crux, 1'b1);
    chk("crux_score", score, 16'd30);

    player_x   = 4'd3;
    player_y   = 4'd2;
    move_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("done_not_ready", move_ready, 1'b0);
    end
    move_valid = 1'b0;

    // Saturation: 13107 rare cells at 5 points reach exactly 16'hFFFF
    do_reset();
    for (int i = 0; i < 150; i++) food[2*i +: 2] = 2'b10;
    for (int k = 0; k < 13107; k++) begin
      if (k > 0 && (k % 150) == 0) regen();
      do_move((k % 150) % 10, (k % 150) / 10);
    end
    settle();
    chk("score_full", score, 16'hFFFF);
    do_move(9, 14);
    settle();
    chk("sat_eat_kind", eat_kind, 2'b10);
    chk("sat_score", score, 16'hFFFF);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
